// File: rtl/ram_pkg.sv
// Shared definitions for the RAM access controller and its RAM-side wrapper:
// default geometry and the burst FSM state encoding.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 5;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int MEM_DEPTH      = 32;
    localparam int LEN_WIDTH      = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_DATA   = 3'd1,
        ST_WR_COMMIT = 3'd2,
        ST_RD_ISSUE  = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_RD_RSP    = 3'd5,
        ST_DONE      = 3'd6
    } ram_state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Client-side bus of the RAM access controller: command, write-beat and
// read-beat handshakes plus the burst-complete pulse.
interface ram_access_ctrl_if
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    logic                  done;

    // Requester side
    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wr_data_valid, wr_data, rsp_ready,
        input  req_ready, wr_data_ready, rsp_valid, rsp_data, rsp_last, done
    );

    // Controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_data_valid, wr_data, rsp_ready,
        output req_ready, wr_data_ready, rsp_valid, rsp_data, rsp_last, done
    );

endinterface

// File: rtl/ram_access_ctrl.sv
// Burst controller in front of a single-port RAM with 1-cycle read latency.
// Keeps exactly one RAM access in flight; every output is a flop so the RAM
// and the client see glitch-free, zero-when-idle drives.
module ram_access_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_ctrl_if.slave      bus,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    ram_state_e            state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  cnt_r;

    logic                  req_ready_r;
    logic                  wr_data_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_last_r;
    logic                  done_r;
    logic                  mem_wr_en_r;
    logic                  mem_rd_en_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

    // Burst FSM: state, beat bookkeeping and all registered outputs.
    // Outputs are loaded on the edge that enters the state they belong to,
    // so each one is valid for exactly the cycles spent in that state.
    // req_ready stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            addr_r          <= ADDR_ZERO;
            len_r           <= 3'd0;
            cnt_r           <= 3'd0;
            req_ready_r     <= 1'b0;
            wr_data_ready_r <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_data_r      <= DATA_ZERO;
            rsp_last_r      <= 1'b0;
            done_r          <= 1'b0;
            mem_wr_en_r     <= 1'b0;
            mem_rd_en_r     <= 1'b0;
            mem_addr_r      <= ADDR_ZERO;
            mem_wdata_r     <= DATA_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (bus.req_valid && req_ready_r) begin
                        addr_r      <= bus.req_addr;
                        len_r       <= bus.req_len;
                        cnt_r       <= 3'd0;
                        req_ready_r <= 1'b0;
                        if (bus.req_write) begin
                            state_r         <= ST_WR_DATA;
                            wr_data_ready_r <= 1'b1;
                        end else begin
                            state_r     <= ST_RD_ISSUE;
                            mem_rd_en_r <= 1'b1;
                            mem_addr_r  <= bus.req_addr;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (bus.wr_data_valid) begin
                        wr_data_ready_r <= 1'b0;
                        mem_wr_en_r     <= 1'b1;
                        mem_addr_r      <= addr_r;
                        mem_wdata_r     <= bus.wr_data;
                        state_r         <= ST_WR_COMMIT;
                    end
                end
                ST_WR_COMMIT: begin
                    mem_wr_en_r <= 1'b0;
                    mem_addr_r  <= ADDR_ZERO;
                    mem_wdata_r <= DATA_ZERO;
                    if (cnt_r == len_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r           <= cnt_r + 3'd1;
                        addr_r          <= addr_r + ADDR_ONE;
                        wr_data_ready_r <= 1'b1;
                        state_r         <= ST_WR_DATA;
                    end
                end
                ST_RD_ISSUE: begin
                    mem_rd_en_r <= 1'b0;
                    mem_addr_r  <= ADDR_ZERO;
                    state_r     <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // RAM data is only valid in this cycle; capture it now.
                    rsp_data_r  <= mem_rdata;
                    rsp_valid_r <= 1'b1;
                    rsp_last_r  <= (cnt_r == len_r);
                    state_r     <= ST_RD_RSP;
                end
                ST_RD_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_last_r  <= 1'b0;
                        rsp_data_r  <= DATA_ZERO;
                        if (cnt_r == len_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r       <= cnt_r + 3'd1;
                            addr_r      <= addr_r + ADDR_ONE;
                            mem_rd_en_r <= 1'b1;
                            mem_addr_r  <= addr_r + ADDR_ONE;
                            state_r     <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r         <= ST_IDLE;
                    req_ready_r     <= 1'b0;
                    wr_data_ready_r <= 1'b0;
                    rsp_valid_r     <= 1'b0;
                    rsp_data_r      <= DATA_ZERO;
                    rsp_last_r      <= 1'b0;
                    done_r          <= 1'b0;
                    mem_wr_en_r     <= 1'b0;
                    mem_rd_en_r     <= 1'b0;
                    mem_addr_r      <= ADDR_ZERO;
                    mem_wdata_r     <= DATA_ZERO;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.wr_data_ready = wr_data_ready_r;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_data      = rsp_data_r;
    assign bus.rsp_last      = rsp_last_r;
    assign bus.done          = done_r;
    assign mem_wr_en         = mem_wr_en_r;
    assign mem_rd_en         = mem_rd_en_r;
    assign mem_addr          = mem_addr_r;
    assign mem_wdata         = mem_wdata_r;

endmodule
